// File: rtl/filter_pkg.sv
// Shared types and kernel helpers for the window filter controller.
// Weights are the binomial rows; S is log2 of the 2-D kernel sum.
package filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PROCESS = 3'd2,
    ST_OUT     = 3'd3,
    ST_FINAL   = 3'd4
  } state_t;

  typedef enum logic {
    MODE_GAUSS  = 1'b0,
    MODE_BYPASS = 1'b1
  } mode_t;

  localparam int MAX_K = 5;

  typedef logic [MAX_K-1:0][3:0] weights_t;

  function automatic weights_t kernel_weights(input int k);
    weights_t w;
    w = '0;
    case (k)
      32'sd3: begin
        w[0] = 4'd1;
        w[1] = 4'd2;
        w[2] = 4'd1;
      end
      32'sd5: begin
        w[0] = 4'd1;
        w[1] = 4'd4;
        w[2] = 4'd6;
        w[3] = 4'd4;
        w[4] = 4'd1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic int shift_bits(input int k);
    int s;
    case (k)
      32'sd3:  s = 32'sd4;
      32'sd5:  s = 32'sd8;
      default: s = 32'sd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Synchronous up-counter with clear, enable and programmable rollover value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  assign rollover_flag = (count_out == rollover_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (rollover_flag) begin
        count_out <= '0;
      end else begin
        count_out <= count_out + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/window_filter_controller.sv
// Strip controller: shifts image columns into a KxROWS window and emits one
// Gaussian-filtered (or centre-bypassed) column of N_OUT pixels per step.
module window_filter_controller
  import filter_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int N_OUT = 16,
  parameter int K     = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [15:0]                    cols_total,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(N_OUT+K-1)*PIX_W-1:0]   in_col,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_OUT*PIX_W-1:0]         out_col,
  output logic                           filter_final,
  output logic                           busy
);

  localparam int ROWS   = N_OUT + K - 1;
  localparam int S      = shift_bits(K);
  localparam int ACC_W  = PIX_W + S;
  localparam int HALF   = (S > 0) ? (1 << (S - 1)) : 0;
  localparam int CENTER = (K - 1) / 2;
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int RW     = $clog2(ROWS);
  localparam weights_t W = kernel_weights(K);

  generate
    if (K != 3 && K != 5) begin : g_bad_k
      $error("window_filter_controller: K must be 3 or 5");
    end
  endgenerate

  state_t             state;
  state_t             next_state;
  mode_t              mode_q;
  logic [15:0]        cols_q;
  logic [15:0]        count;
  logic [15:0]        count_inc;
  logic               accept;
  logic [IDX_W-1:0]   idx;
  logic               idx_last;
  logic [PIX_W-1:0]   pix;
  logic [PIX_W-1:0]   win [K][ROWS];

  flex_counter #(
    .WIDTH(IDX_W)
  ) u_index (
    .clk          (clk),
    .rst          (rst),
    .clear        (state != ST_PROCESS),
    .count_enable (state == ST_PROCESS),
    .rollover_val (IDX_W'(N_OUT - 1)),
    .count_out    (idx),
    .rollover_flag(idx_last)
  );

  // Next-state logic; the accepted count is compared after the increment.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    count_inc  = count + 16'd1;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (cols_total == 16'd0) ? ST_FINAL : ST_LOAD;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          if (count_inc >= 16'(K)) begin
            next_state = ST_PROCESS;
          end else if (count_inc == cols_q) begin
            next_state = ST_FINAL;
          end else begin
            next_state = ST_LOAD;
          end
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_PROCESS: begin
        if (idx_last) begin
          next_state = ST_OUT;
        end else begin
          next_state = ST_PROCESS;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          next_state = (count == cols_q) ? ST_FINAL : ST_LOAD;
        end else begin
          next_state = ST_OUT;
        end
      end
      ST_FINAL: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Handshake/status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      filter_final <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= next_state;
      in_ready     <= (next_state == ST_LOAD);
      out_valid    <= (next_state == ST_OUT);
      filter_final <= (next_state == ST_FINAL);
      busy         <= (next_state != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 16'd0;
      cols_q <= 16'd0;
      mode_q <= MODE_GAUSS;
      for (int c = 0; c < K; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          win[c][r] <= '0;
        end
      end
    end else if (state == ST_IDLE && start) begin
      count  <= 16'd0;
      cols_q <= cols_total;
      mode_q <= mode_t'(mode);
      for (int c = 0; c < K; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          win[c][r] <= '0;
        end
      end
    end else if (accept) begin
      count <= count_inc;
      // Column K-1 is newest; column 0 falls off the window.
      for (int c = 0; c < K - 1; c++) begin
        win[c] <= win[c+1];
      end
      for (int r = 0; r < ROWS; r++) begin
        win[K-1][r] <= in_col[r*PIX_W +: PIX_W];
      end
    end
  end

  // One output pixel per PROCESS cycle, rows idx..idx+K-1.
  always_comb begin
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] rounded;
    logic [RW-1:0]    row;
    acc     = '0;
    rounded = '0;
    row     = '0;
    for (int r = 0; r < K; r++) begin
      row = RW'(idx) + RW'(r);
      for (int c = 0; c < K; c++) begin
        acc = acc + ACC_W'(W[r]) * ACC_W'(W[c]) * ACC_W'(win[c][row]);
      end
    end
    rounded = acc + ACC_W'(HALF);
    if (mode_q == MODE_BYPASS) begin
      pix = win[CENTER][RW'(idx) + RW'(CENTER)];
    end else begin
      pix = rounded[S +: PIX_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_col <= '0;
    end else if (state == ST_PROCESS) begin
      out_col[idx*PIX_W +: PIX_W] <= pix;
    end
  end

endmodule

// File: doc/window_filter_controller.md
WINDOW_FILTER_CONTROLLER -- requirements
Module: window_filter_controller

Interface
REQ-001 Parameter PIX_W, 8, pixel width in bits.
REQ-002 Parameter N_OUT, 16, output pixels per strip column.
REQ-003 Parameter K, 5, kernel size; legal values 3 or 5 only.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1, reset; synchronous and active-high.
REQ-006 Port start, input, 1, one-cycle pulse that begins a new strip; ignored unless in IDLE.
REQ-007 Port cols_total, input, 16, strip length in columns; sampled on start.
REQ-008 Port mode, input, 1, 0 = GAUSS, 1 = BYPASS; sampled on start.
REQ-009 Port in_valid, input, 1, input column valid.
REQ-010 Port in_ready, output, 1, controller accepts a column.
REQ-011 Port in_col, input, (N_OUT+K-1) x PIX_W, one image column, row 0 first.
REQ-012 Port out_valid, output, 1, output column valid.
REQ-013 Port out_ready, input, 1, consumer accepts the output column.
REQ-014 Port out_col, output, N_OUT x PIX_W, filtered column, registered.
REQ-015 Port filter_final, output, 1, one-cycle pulse when the strip is complete.
REQ-016 Port busy, output, 1, high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, LOAD, PROCESS, OUT and FINAL.
REQ-018 IDLE+start: window cleared, accepted-column count = 0; next state LOAD, or FINAL if cols_total = 0.
REQ-019 LOAD: in_ready = 1; on in_valid&in_ready the window shifts one column (oldest column dropped, in_col becomes newest) and the accepted count increments.
REQ-020 LOAD, after an accept: with count >= K, go to PROCESS; with count < K and count = cols_total, go to FINAL; otherwise stay in LOAD.
REQ-021 PROCESS: index counter runs 0..N_OUT-1, one pixel per cycle, writing out_col[index]; at index N_OUT-1 go to OUT.
REQ-022 Pixel i SHALL use window rows i..i+K-1 across all K columns.
REQ-023 GAUSS: separable binomial weights ([1,2,1] for K=3, [1,4,6,4,1] for K=5); pixel = (sum w_r*w_c*p + half) >> S, where S = 4 for K=3 and 8 for K=5, and half = 2^(S-1).
REQ-024 The accumulator width SHALL be PIX_W+S with no overflow; the result SHALL NOT saturate, since its maximum is 2^PIX_W-1.
REQ-025 BYPASS: pixel i = window centre column, row i+(K-1)/2.
REQ-026 OUT: out_valid = 1 and out_col held stable until out_ready; on the handshake go to FINAL if count = cols_total, else LOAD.
REQ-027 Latency: a column accepted at edge t produces out_valid high in cycle t+N_OUT+1 (LOAD accept, then N_OUT PROCESS cycles).
REQ-028 A strip SHALL produce exactly max(0, cols_total-K+1) output columns.
REQ-029 in_ready SHALL be 0 in all states except LOAD; there is no input buffering.
REQ-030 FINAL: filter_final = 1 for exactly one cycle, then go to IDLE.
REQ-031 start outside IDLE SHALL have no effect; mode and cols_total SHALL be constant for the whole strip.

Reset
REQ-032 rst high at a clock edge: state = IDLE; count, index and window = 0; out_col = 0; in_ready, out_valid, filter_final and busy = 0.
REQ-033 Reset mid-strip SHALL abort the strip with no filter_final pulse; the next start SHALL behave as if from power-up.

Structure
REQ-034 Package filter_pkg SHALL hold the state enum, the mode enum, a function returning the weights per K, and a function returning S per K.
REQ-035 The index counter SHALL be the existing flex_counter instance, with clear driven in all states except PROCESS; no other sub-module.
REQ-036 A K outside {3,5} SHALL be rejected at elaboration.

Verification
REQ-037 K=5, GAUSS, cols_total=8, all pixels 100 -> 4 output columns, every pixel 100, then one filter_final pulse.
REQ-038 K=3, GAUSS, single pixel 255 at window centre, otherwise 0 -> that output pixel 64 (K=5 case: 36); all other outputs of that column 0 or exactly per kernel.
REQ-039 K=5, BYPASS, ramp with pixel = row index -> out_col[i] = i+2 in every column.
REQ-040 cols_total=2 with K=3 -> two accepts, no out_valid, filter_final 1 cycle later; cols_total=0 -> filter_final with zero accepts.
REQ-041 out_ready held low 10 cycles -> out_col stable, in_ready 0 throughout; after release the next column proceeds with correct data.
REQ-042 rst asserted during PROCESS -> next cycle all outputs 0 and state IDLE, no filter_final; a fresh strip then matches REQ-037.
